// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin increment scheduler.
// The state encoding and the grant-index width rule are used by the top level and by rr_pick.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHold    = 2'd1,
    StRefresh = 2'd2
  } sched_state_e;

  // Width of an index into a set of d requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction

  // Width of a counter that has to reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first pending index found by searching from ptr upward, wrapping modulo DIGITS.
module rr_pick
  import counter_sched_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  localparam int unsigned IDXW  = idx_width(DIGITS)
) (
  input  logic [DIGITS-1:0] pending,
  input  logic [IDXW-1:0]   ptr,
  output logic [IDXW-1:0]   sel,
  output logic              valid
);

  logic [IDXW-1:0] idx;

  // Walk the offsets from highest to lowest, so the smallest offset from ptr is written last
  // and therefore wins.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      idx = IDXW'((int'(ptr) + k) % int'(DIGITS));
      if (pending[idx]) begin
        sel   = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_inc_scheduler.sv
// Queues button presses and grants one digit increment per tick slot, in round-robin order.
// After each grant it holds off for HOLDOFF cycles, then issues a single display refresh.
module counter_inc_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned DIGITS  = 3,
  parameter int unsigned HOLDOFF = 4,
  localparam int unsigned IDXW   = idx_width(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] req,
  input  logic              tick,
  input  logic              shift_busy,
  output logic [DIGITS-1:0] inc_pulse,
  output logic [IDXW-1:0]   grant_idx,
  output logic              refresh_req,
  output logic [DIGITS-1:0] pending,
  output logic              busy
);

  localparam int unsigned HCW = cnt_width(HOLDOFF);

  sched_state_e      state_q, state_d;
  logic [DIGITS-1:0] pending_q, pending_d;
  logic [DIGITS-1:0] req_prev_q;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DIGITS-1:0] inc_pulse_q, inc_pulse_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic              refresh_q, refresh_d;
  logic              busy_q;

  logic [DIGITS-1:0] rise;
  logic [DIGITS-1:0] clear;
  logic [IDXW-1:0]   sel;
  logic              sel_valid;

  rr_pick #(
    .DIGITS (DIGITS)
  ) u_rr_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .sel     (sel),
    .valid   (sel_valid)
  );

  always_comb begin
    rise        = req & ~req_prev_q;
    clear       = '0;
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    inc_pulse_d = '0;
    grant_idx_d = grant_idx_q;
    refresh_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (tick && sel_valid) begin
          inc_pulse_d = DIGITS'(1) << sel;
          grant_idx_d = sel;
          clear[sel]  = 1'b1;
          ptr_d       = (sel == IDXW'(DIGITS - 1)) ? '0 : sel + IDXW'(1);
          hold_cnt_d  = '0;
          state_d     = StHold;
        end
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q + HCW'(1);
        if (hold_cnt_q == HCW'(HOLDOFF - 1)) begin
          state_d = StRefresh;
        end
      end
      StRefresh: begin
        if (!shift_busy) begin
          refresh_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A fresh rise on the digit being granted must survive its own clear.
    pending_d = (pending_q & ~clear) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      req_prev_q  <= '0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      inc_pulse_q <= '0;
      grant_idx_q <= '0;
      refresh_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      req_prev_q  <= req;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      inc_pulse_q <= inc_pulse_d;
      grant_idx_q <= grant_idx_d;
      refresh_q   <= refresh_d;
      busy_q      <= (state_d != StIdle);
    end
  end

  assign inc_pulse   = inc_pulse_q;
  assign grant_idx   = grant_idx_q;
  assign refresh_req = refresh_q;
  assign pending     = pending_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_counter_inc_scheduler.sv
// Directed bench for counter_inc_scheduler (DIGITS=3, HOLDOFF=4).
// Cycle n is the interval after the n-th clock edge that follows the start of a sequence.
module tb_counter_inc_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic       tick;
  logic       shift_busy;
  logic [2:0] inc_pulse;
  logic [1:0] grant_idx;
  logic       refresh_req;
  logic [2:0] pending;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cur_cyc  = 0;

  logic [2:0] inc_log [0:127];
  logic       ref_log [0:127];

  counter_inc_scheduler #(
    .DIGITS  (3),
    .HOLDOFF (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .tick        (tick),
    .shift_busy  (shift_busy),
    .inc_pulse   (inc_pulse),
    .grant_idx   (grant_idx),
    .refresh_req (refresh_req),
    .pending     (pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    req        = '0;
    tick       = 1'b1;
    shift_busy = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic start_seq();
    cur_cyc = 0;
    for (int i = 0; i < 128; i++) begin
      inc_log[i] = '0;
      ref_log[i] = 1'b0;
    end
  endtask

  task automatic run_to(input int last);
    while (cur_cyc < last) begin
      step();
      cur_cyc++;
      inc_log[cur_cyc] = inc_pulse;
      ref_log[cur_cyc] = refresh_req;
    end
  endtask

  function automatic int count_inc(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (inc_log[i] != 3'b000) n++;
    return n;
  endfunction

  function automatic int count_ref(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (ref_log[i]) n++;
    return n;
  endfunction

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_inc", 32'(inc_pulse), 0);
    check_eq("rst_gidx", 32'(grant_idx), 0);
    check_eq("rst_ref", 32'(refresh_req), 0);
    check_eq("rst_pend", 32'(pending), 0);
    check_eq("rst_busy", 32'(busy), 0);

    // Single press on digit 1 with tick held high
    start_seq();
    req = 3'b010;
    run_to(1);
    check_eq("t1_pend_c1", 32'(pending), 32'b010);
    check_eq("t1_inc_c1", 32'(inc_pulse), 0);
    run_to(2);
    check_eq("t1_inc_c2", 32'(inc_pulse), 32'b010);
    check_eq("t1_gidx_c2", 32'(grant_idx), 1);
    check_eq("t1_busy_c2", 32'(busy), 1);
    check_eq("t1_pend_c2", 32'(pending), 0);
    run_to(6);
    check_eq("t1_busy_c6", 32'(busy), 1);
    check_eq("t1_ref_c6", 32'(refresh_req), 0);
    run_to(7);
    check_eq("t1_ref_c7", 32'(refresh_req), 1);
    check_eq("t1_busy_c7", 32'(busy), 0);
    run_to(30);
    check_eq("t1_n_inc", 32'(count_inc(1, 30)), 1);
    check_eq("t1_n_ref", 32'(count_ref(1, 30)), 1);
    check_eq("t1_gidx_hold", 32'(grant_idx), 1);

    // ptr now points at digit 2; digits 0 and 2 pressed together
    start_seq();
    req = 3'b101;
    run_to(20);
    check_eq("t3_inc_c2", 32'(inc_log[2]), 32'b100);
    check_eq("t3_inc_c8", 32'(inc_log[8]), 32'b001);
    check_eq("t3_n_inc", 32'(count_inc(1, 20)), 2);
    check_eq("t3_gidx", 32'(grant_idx), 0);

    // Three simultaneous presses from ptr=0
    do_reset();
    start_seq();
    req = 3'b111;
    run_to(30);
    check_eq("t2_inc_c2", 32'(inc_log[2]), 32'b001);
    check_eq("t2_inc_c8", 32'(inc_log[8]), 32'b010);
    check_eq("t2_inc_c14", 32'(inc_log[14]), 32'b100);
    check_eq("t2_n_inc", 32'(count_inc(1, 30)), 3);
    check_eq("t2_n_ref", 32'(count_ref(1, 30)), 3);
    check_eq("t2_ref_c7", 32'(ref_log[7]), 1);
    check_eq("t2_pend_end", 32'(pending), 0);

    // Shifter busy blocks the refresh and any further grant
    do_reset();
    start_seq();
    req        = 3'b101;
    shift_busy = 1'b1;
    run_to(16);
    shift_busy = 1'b0;
    run_to(30);
    check_eq("t4_inc_c2", 32'(inc_log[2]), 32'b001);
    check_eq("t4_ref_blocked", 32'(count_ref(1, 16)), 0);
    check_eq("t4_inc_blocked", 32'(count_inc(3, 17)), 0);
    check_eq("t4_ref_c17", 32'(ref_log[17]), 1);
    check_eq("t4_inc_c18", 32'(inc_log[18]), 32'b100);
    check_eq("t4_n_ref", 32'(count_ref(1, 30)), 2);

    // Long hold counts once; a re-press during HOLD is queued and served next slot
    do_reset();
    start_seq();
    req = 3'b001;
    run_to(50);
    check_eq("t5_n_inc_held", 32'(count_inc(1, 50)), 1);
    check_eq("t5_inc_c2", 32'(inc_log[2]), 32'b001);
    req = 3'b000;
    run_to(51);
    req = 3'b001;
    run_to(53);
    check_eq("t5_inc_c53", 32'(inc_pulse), 32'b001);
    req = 3'b000;
    run_to(54);
    req = 3'b001;
    run_to(55);
    check_eq("t5_pend_hold", 32'(pending), 32'b001);
    check_eq("t5_busy_hold", 32'(busy), 1);
    run_to(65);
    check_eq("t5_none_hold", 32'(count_inc(54, 58)), 0);
    check_eq("t5_ref_c58", 32'(ref_log[58]), 1);
    check_eq("t5_inc_c59", 32'(inc_log[59]), 32'b001);

    // No tick means no grant; then reset in the middle of HOLD
    do_reset();
    start_seq();
    tick = 1'b0;
    req  = 3'b100;
    run_to(20);
    check_eq("t6_n_inc_notick", 32'(count_inc(1, 20)), 0);
    check_eq("t6_pend", 32'(pending), 32'b100);
    tick = 1'b1;
    run_to(21);
    check_eq("t6_inc_c21", 32'(inc_pulse), 32'b100);
    check_eq("t6_gidx_c21", 32'(grant_idx), 2);
    run_to(22);
    reset = 1'b1;
    req   = 3'b000;
    run_to(23);
    check_eq("t6_rst_inc", 32'(inc_pulse), 0);
    check_eq("t6_rst_gidx", 32'(grant_idx), 0);
    check_eq("t6_rst_ref", 32'(refresh_req), 0);
    check_eq("t6_rst_pend", 32'(pending), 0);
    check_eq("t6_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    run_to(45);
    check_eq("t6_no_ref_after", 32'(count_ref(23, 45)), 0);
    check_eq("t6_no_inc_after", 32'(count_inc(23, 45)), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
